wash_cycle_timer: RTL and testbench
===================================

Name: wash_cycle_timer

Overview:
Program-driven phase timer that sequences the automatic washing machine controller. It watches the controller's actuator outputs (motor_on, soap_wash, water_wash, drain_value_on, door_lock, done), times each phase against a selectable wash program, and drives the controller's cycle_timeout and spin_timeout inputs. It also repeats the rinse phase internally for multi-rinse programs. It sits beside the washing-machine FSM in the top level and replaces the testbench-driven timeout stimulus.

Parameters:
TICK_DIV, 4, clock cycles per time unit (must be >= 2)
CNT_W, 8, width of phase countdown and time_remaining

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
program_sel  input  2  0=quick, 1=normal, 2=heavy, 3=reserved (treated as normal); latched on entry to WASH
pause  input  1  while high, prescaler and countdown hold; state and outputs hold
door_lock  input  1  from controller; low while timing => abort
motor_on  input  1  from controller
soap_wash  input  1  from controller
water_wash  input  1  from controller
drain_value_on  input  1  from controller
done  input  1  from controller; returns timer to IDLE
cycle_timeout  output  1  to controller; level, wash/final-rinse expired
spin_timeout  output  1  to controller; level, spin expired
phase  output  2  0=IDLE, 1=WASH, 2=RINSE, 3=SPIN
time_remaining  output  CNT_W  current countdown value in time units
rinse_idx  output  2  rinse currently running (1-based, 0 outside RINSE)
aborted  output  1  one-cycle pulse on door-lock abort

Behaviour:
- Reset (sync, active-high): phase=IDLE; cycle_timeout=0, spin_timeout=0, time_remaining=0, rinse_idx=0, aborted=0; prescaler=0; latched program=normal.
- Program table (time units): quick: wash 4, rinses 1, rinse 2, spin 3. normal: wash 8, rinses 2, rinse 3, spin 5. heavy: wash 12, rinses 3, rinse 4, spin 6.
- Phase detect (sampled each clk): W = motor_on&soap_wash; R = motor_on&water_wash&!soap_wash; S = motor_on&drain_value_on&!soap_wash&!water_wash.
- IDLE->WASH on W: latch program, load wash time, prescaler=0.
- WASH->RINSE on R, and RINSE->SPIN on S, from any phase whose timeout is asserted or whose count is 0: load that phase's duration, prescaler=0, clear the timeout flags. rinse_idx=1 on RINSE entry.
- Tick: prescaler counts 0..TICK_DIV-1 and ticks on TICK_DIV-1; counter decrements on tick while >0 and !pause.
- Expiry: the edge where the counter goes 1->0.
  - WASH: cycle_timeout=1 at that edge.
  - RINSE with rinse_idx < rinses: reload rinse time, rinse_idx++, no timeout.
  - RINSE on the last rinse: cycle_timeout=1.
  - SPIN: spin_timeout=1.
- Latency: a timeout is visible exactly D*TICK_DIV cycles after the load edge, with no pause.
- cycle_timeout holds until the next phase load, done, abort or reset. spin_timeout holds until done, abort or reset.
- done=1 in any phase -> IDLE next edge; all outputs are cleared.
- Abort: door_lock=0 while phase!=IDLE -> IDLE, outputs cleared, aborted=1 for one cycle. Abort has priority over done, which has priority over phase transitions.
- Simultaneous tick and phase-load: the load wins.
- pause during expiry cycle: no expiry.
- Reset mid-phase: immediate IDLE; no timeout is asserted.
- A phase-detect signal that does not match the legal next phase is ignored (no reload).
- Counter never wraps below 0. The largest duration must fit in CNT_W bits.

Decomposition:
- Package wash_pkg holds:
  - the phase enum (IDLE/WASH/RINSE/SPIN);
  - the program enum (QUICK/NORMAL/HEAVY);
  - a struct {wash_t, rinse_cnt, rinse_t, spin_t};
  - a constant function prog_lookup(program_sel) returning that struct (reserved code maps to normal).
- One sub-module, wash_tick_prescaler: counter with clear and hold inputs and a tick output.

Test Plan:
All cases use TICK_DIV=4.
- Normal program: program_sel=1, door_lock=1, W rises at edge 10 -> phase=1, time_remaining=8; cycle_timeout=1 at edge 42; time_remaining=0.
- Heavy rinse repeat: R asserted -> rinse_idx 1->2->3 at +16 and +32 cycles with no timeout; cycle_timeout=1 at +48; phase=2.
- Quick spin: S after rinse timeout -> phase=3, time_remaining=3; spin_timeout=1 at +12 cycles; done=1 -> phase=0, spin_timeout=0 next edge.
- Pause: normal wash, pause high for 10 cycles mid-count -> cycle_timeout delayed to edge 52; time_remaining frozen during pause.
- Abort: door_lock drops during SPIN with time_remaining=2 -> aborted=1 for one cycle, phase=0, spin_timeout stays 0; a simultaneous done does not suppress aborted.
- Reset mid-wash at count 5 -> all outputs 0 next edge. program_sel=3 -> wash time 8.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared types and wash program table for the wash cycle timer.
// Program durations are in prescaled time units.
package wash_pkg;

    localparam int DUR_W = 8;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_WASH  = 2'd1,
        PH_RINSE = 2'd2,
        PH_SPIN  = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        PROG_QUICK  = 2'd0,
        PROG_NORMAL = 2'd1,
        PROG_HEAVY  = 2'd2
    } prog_e;

    typedef struct packed {
        logic [DUR_W-1:0] wash_t;
        logic [1:0]       rinse_cnt;
        logic [DUR_W-1:0] rinse_t;
        logic [DUR_W-1:0] spin_t;
    } prog_cfg_t;

    // The reserved selector code behaves exactly like the normal program.
    function automatic prog_cfg_t prog_lookup(input logic [1:0] program_sel);
        prog_cfg_t cfg;
        case (program_sel)
            2'd0:    cfg = '{wash_t: 8'd4,  rinse_cnt: 2'd1, rinse_t: 8'd2, spin_t: 8'd3};
            2'd2:    cfg = '{wash_t: 8'd12, rinse_cnt: 2'd3, rinse_t: 8'd4, spin_t: 8'd6};
            default: cfg = '{wash_t: 8'd8,  rinse_cnt: 2'd2, rinse_t: 8'd3, spin_t: 8'd5};
        endcase
        return cfg;
    endfunction

    function automatic prog_e prog_decode(input logic [1:0] program_sel);
        prog_e p;
        case (program_sel)
            2'd0:    p = PROG_QUICK;
            2'd2:    p = PROG_HEAVY;
            default: p = PROG_NORMAL;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/wash_tick_prescaler.sv
// Free-running 0..TICK_DIV-1 prescaler producing a one-cycle time-unit tick.
// Clear restarts the count at zero; hold freezes it and suppresses the tick.
module wash_tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PRE_ONE  = PW'(32'd1);

    logic [PW-1:0] pre_r;

    // Prescaler count register: clear beats hold, hold beats counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_r <= PRE_ZERO;
        end else if (clear) begin
            pre_r <= PRE_ZERO;
        end else if (hold) begin
            pre_r <= pre_r;
        end else if (pre_r == PRE_LAST) begin
            pre_r <= PRE_ZERO;
        end else begin
            pre_r <= pre_r + PRE_ONE;
        end
    end

    assign tick = (pre_r == PRE_LAST) && !hold;

endmodule

// File: rtl/wash_cycle_timer.sv
// Phase timer beside the washing-machine FSM: follows actuator outputs, times
// each phase for the selected program and raises cycle/spin timeouts.
module wash_cycle_timer
    import wash_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       program_sel,
    input  logic             pause,
    input  logic             door_lock,
    input  logic             motor_on,
    input  logic             soap_wash,
    input  logic             water_wash,
    input  logic             drain_value_on,
    input  logic             done,
    output logic             cycle_timeout,
    output logic             spin_timeout,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] time_remaining,
    output logic [1:0]       rinse_idx,
    output logic             aborted
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    phase_e           phase_r, phase_n;
    prog_e            prog_r, prog_n;
    logic [CNT_W-1:0] count_r, count_n;
    logic             cto_r, cto_n;
    logic             sto_r, sto_n;
    logic [1:0]       ridx_r, ridx_n;
    logic             aborted_r, aborted_n;

    prog_cfg_t        cfg_s;
    logic [1:0]       cfg_sel_s;
    logic             w_s, r_s, s_s;
    logic             abort_s, phase_over_s, load_s, clear_s, tick_s;

    wash_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .hold  (pause),
        .tick  (tick_s)
    );

    // Phase detection and load decision; kept apart from the tick path.
    always_comb begin
        w_s          = motor_on & soap_wash;
        r_s          = motor_on & water_wash & ~soap_wash;
        s_s          = motor_on & drain_value_on & ~soap_wash & ~water_wash;
        abort_s      = (phase_r != PH_IDLE) && !door_lock;
        phase_over_s = cto_r || (count_r == CNT_ZERO);
        load_s       = 1'b0;
        if (abort_s || done) begin
            load_s = 1'b0;
        end else begin
            case (phase_r)
                PH_IDLE:  load_s = w_s;
                PH_WASH:  load_s = r_s && phase_over_s;
                PH_RINSE: load_s = s_s && phase_over_s;
                default:  load_s = 1'b0;
            endcase
        end
    end

    assign clear_s   = load_s || abort_s || done || (phase_r == PH_IDLE);
    // In IDLE the table follows the live selector so WASH loads the new program.
    assign cfg_sel_s = (phase_r == PH_IDLE) ? program_sel : prog_r;
    assign cfg_s     = prog_lookup(cfg_sel_s);

    // Next-state: abort, then done, then phase loads, then countdown.
    always_comb begin
        phase_n   = phase_r;
        prog_n    = prog_r;
        count_n   = count_r;
        cto_n     = cto_r;
        sto_n     = sto_r;
        ridx_n    = ridx_r;
        aborted_n = 1'b0;
        if (abort_s || done) begin
            phase_n   = PH_IDLE;
            count_n   = CNT_ZERO;
            cto_n     = 1'b0;
            sto_n     = 1'b0;
            ridx_n    = 2'd0;
            aborted_n = abort_s;
        end else if (load_s) begin
            cto_n = 1'b0;
            sto_n = 1'b0;
            case (phase_r)
                PH_IDLE: begin
                    phase_n = PH_WASH;
                    prog_n  = prog_decode(program_sel);
                    count_n = CNT_W'(cfg_s.wash_t);
                    ridx_n  = 2'd0;
                end
                PH_WASH: begin
                    phase_n = PH_RINSE;
                    count_n = CNT_W'(cfg_s.rinse_t);
                    ridx_n  = 2'd1;
                end
                PH_RINSE: begin
                    phase_n = PH_SPIN;
                    count_n = CNT_W'(cfg_s.spin_t);
                    ridx_n  = 2'd0;
                end
                default: begin
                    phase_n = PH_IDLE;
                    count_n = CNT_ZERO;
                    ridx_n  = 2'd0;
                end
            endcase
        end else if (tick_s && (count_r != CNT_ZERO) && (phase_r != PH_IDLE)) begin
            if (count_r == CNT_ONE) begin
                case (phase_r)
                    PH_WASH: begin
                        count_n = CNT_ZERO;
                        cto_n   = 1'b1;
                    end
                    PH_RINSE: begin
                        if (ridx_r < cfg_s.rinse_cnt) begin
                            count_n = CNT_W'(cfg_s.rinse_t);
                            ridx_n  = ridx_r + 2'd1;
                        end else begin
                            count_n = CNT_ZERO;
                            cto_n   = 1'b1;
                        end
                    end
                    PH_SPIN: begin
                        count_n = CNT_ZERO;
                        sto_n   = 1'b1;
                    end
                    default: count_n = CNT_ZERO;
                endcase
            end else begin
                count_n = count_r - CNT_ONE;
            end
        end else begin
            count_n = count_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r   <= PH_IDLE;
            prog_r    <= PROG_NORMAL;
            count_r   <= CNT_ZERO;
            cto_r     <= 1'b0;
            sto_r     <= 1'b0;
            ridx_r    <= 2'd0;
            aborted_r <= 1'b0;
        end else begin
            phase_r   <= phase_n;
            prog_r    <= prog_n;
            count_r   <= count_n;
            cto_r     <= cto_n;
            sto_r     <= sto_n;
            ridx_r    <= ridx_n;
            aborted_r <= aborted_n;
        end
    end

    assign phase          = phase_r;
    assign time_remaining = count_r;
    assign cycle_timeout  = cto_r;
    assign spin_timeout   = sto_r;
    assign rinse_idx      = ridx_r;
    assign aborted        = aborted_r;

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Scoreboard bench for wash_cycle_timer: expected output snapshots are queued
// against absolute clock-edge numbers and compared on the following negedge.
module tb_wash_cycle_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] program_sel = 2'd1;
    logic       pause = 1'b0, door_lock = 1'b0, motor_on = 1'b0, soap_wash = 1'b0;
    logic       water_wash = 1'b0, drain_value_on = 1'b0, done = 1'b0;
    logic       cycle_timeout, spin_timeout, aborted;
    logic [1:0] phase, rinse_idx;
    logic [7:0] time_remaining;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    typedef struct {
        int          at;
        logic [14:0] v;
        string       tag;
    } exp_t;
    exp_t sb[$];

    wash_cycle_timer #(.TICK_DIV(4), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .program_sel    (program_sel),
        .pause          (pause),
        .door_lock      (door_lock),
        .motor_on       (motor_on),
        .soap_wash      (soap_wash),
        .water_wash     (water_wash),
        .drain_value_on (drain_value_on),
        .done           (done),
        .cycle_timeout  (cycle_timeout),
        .spin_timeout   (spin_timeout),
        .phase          (phase),
        .time_remaining (time_remaining),
        .rinse_idx      (rinse_idx),
        .aborted        (aborted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Packed layout: {phase, time_remaining, cycle_timeout, spin_timeout, rinse_idx, aborted}
    function automatic logic [14:0] mk(input logic [1:0] ph, input logic [7:0] tr,
                                       input logic cto, input logic sto,
                                       input logic [1:0] ri, input logic ab);
        return {ph, tr, cto, sto, ri, ab};
    endfunction

    function automatic logic [14:0] obs();
        return {phase, time_remaining, cycle_timeout, spin_timeout, rinse_idx, aborted};
    endfunction

    function automatic void push(input int at, input logic [14:0] v, input string tag);
        sb.push_back('{at, v, tag});
    endfunction

    task automatic drive_act(input logic m, input logic s, input logic w, input logic d);
        motor_on = m; soap_wash = s; water_wash = w; drain_value_on = d;
    endtask

    task automatic do_reset();
        reset = 1'b1; done = 1'b0; pause = 1'b0; door_lock = 1'b1;
        drive_act(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        push(1, mk(2'd0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0), "reset_e1");
        push(2, mk(2'd0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0), "reset_e2");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        reset = 1'b0; door_lock = 1'b1;
        push(edge_cnt + 3, mk(2'd0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0), "idle_hold");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
    endtask

    task automatic test_normal_wash();
        exp_t e;
        int l;
        do_reset();
        program_sel = 2'd1;
        drive_act(1'b1, 1'b1, 1'b0, 1'b0);
        l = edge_cnt + 1;
        push(l,      mk(2'd1, 8'd8, 1'b0, 1'b0, 2'd0, 1'b0), "wash_load");
        push(l + 3,  mk(2'd1, 8'd8, 1'b0, 1'b0, 2'd0, 1'b0), "wash_pre_tick");
        push(l + 4,  mk(2'd1, 8'd7, 1'b0, 1'b0, 2'd0, 1'b0), "wash_first_tick");
        push(l + 31, mk(2'd1, 8'd1, 1'b0, 1'b0, 2'd0, 1'b0), "wash_before_exp");
        push(l + 32, mk(2'd1, 8'd0, 1'b1, 1'b0, 2'd0, 1'b0), "wash_timeout");
        push(l + 40, mk(2'd1, 8'd0, 1'b1, 1'b0, 2'd0, 1'b0), "wash_timeout_hold");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        done = 1'b1;
        drive_act(1'b0, 1'b0, 1'b0, 1'b0);
        push(edge_cnt + 1, mk(2'd0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0), "wash_done_clear");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_heavy_rinse();
        exp_t e;
        int l, r0;
        do_reset();
        program_sel = 2'd2;
        drive_act(1'b1, 1'b1, 1'b0, 1'b0);
        l = edge_cnt + 1;
        push(l, mk(2'd1, 8'd12, 1'b0, 1'b0, 2'd0, 1'b0), "heavy_wash_load");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        // Rinse request arrives early and must be ignored until wash expires.
        drive_act(1'b1, 1'b0, 1'b1, 1'b0);
        r0 = l + 49;
        push(l + 20, mk(2'd1, 8'd7, 1'b0, 1'b0, 2'd0, 1'b0), "heavy_early_r_ignored");
        push(l + 48, mk(2'd1, 8'd0, 1'b1, 1'b0, 2'd0, 1'b0), "heavy_wash_timeout");
        push(r0,      mk(2'd2, 8'd4, 1'b0, 1'b0, 2'd1, 1'b0), "rinse1_load");
        push(r0 + 15, mk(2'd2, 8'd1, 1'b0, 1'b0, 2'd1, 1'b0), "rinse1_end");
        push(r0 + 16, mk(2'd2, 8'd4, 1'b0, 1'b0, 2'd2, 1'b0), "rinse2_reload");
        push(r0 + 32, mk(2'd2, 8'd4, 1'b0, 1'b0, 2'd3, 1'b0), "rinse3_reload");
        push(r0 + 47, mk(2'd2, 8'd1, 1'b0, 1'b0, 2'd3, 1'b0), "rinse3_end");
        push(r0 + 48, mk(2'd2, 8'd0, 1'b1, 1'b0, 2'd3, 1'b0), "rinse_final_timeout");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
    endtask

    task automatic test_quick_spin(input logic do_abort);
        exp_t e;
        int l;
        do_reset();
        program_sel = 2'd0;
        drive_act(1'b1, 1'b1, 1'b0, 1'b0);
        l = edge_cnt + 1;
        @(negedge clk);
        drive_act(1'b1, 1'b0, 1'b1, 1'b0);
        push(l + 16, mk(2'd1, 8'd0, 1'b1, 1'b0, 2'd0, 1'b0), "quick_wash_timeout");
        push(l + 17, mk(2'd2, 8'd2, 1'b0, 1'b0, 2'd1, 1'b0), "quick_rinse_load");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        drive_act(1'b1, 1'b0, 1'b0, 1'b1);
        push(l + 25, mk(2'd2, 8'd0, 1'b1, 1'b0, 2'd1, 1'b0), "quick_rinse_timeout");
        push(l + 26, mk(2'd3, 8'd3, 1'b0, 1'b0, 2'd0, 1'b0), "spin_load");
        push(l + 30, mk(2'd3, 8'd2, 1'b0, 1'b0, 2'd0, 1'b0), "spin_count2");
        if (!do_abort) begin
            push(l + 37, mk(2'd3, 8'd1, 1'b0, 1'b0, 2'd0, 1'b0), "spin_before_exp");
            push(l + 38, mk(2'd3, 8'd0, 1'b0, 1'b1, 2'd0, 1'b0), "spin_timeout");
            push(l + 40, mk(2'd3, 8'd0, 1'b0, 1'b1, 2'd0, 1'b0), "spin_timeout_hold");
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        done = 1'b1;
        if (do_abort) begin
            door_lock = 1'b0;
            push(edge_cnt + 1, mk(2'd0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b1), "abort_pulse");
            push(edge_cnt + 2, mk(2'd0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0), "abort_pulse_end");
        end else begin
            push(edge_cnt + 1, mk(2'd0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0), "spin_done_clear");
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_pause();
        exp_t e;
        int l;
        do_reset();
        program_sel = 2'd1;
        drive_act(1'b1, 1'b1, 1'b0, 1'b0);
        l = edge_cnt + 1;
        push(l + 4,  mk(2'd1, 8'd7, 1'b0, 1'b0, 2'd0, 1'b0), "pause_pre_t4");
        push(l + 12, mk(2'd1, 8'd5, 1'b0, 1'b0, 2'd0, 1'b0), "pause_pre_t12");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        pause = 1'b1;
        push(l + 16, mk(2'd1, 8'd5, 1'b0, 1'b0, 2'd0, 1'b0), "pause_frozen_mid");
        push(l + 22, mk(2'd1, 8'd5, 1'b0, 1'b0, 2'd0, 1'b0), "pause_frozen_end");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        pause = 1'b0;
        push(l + 26, mk(2'd1, 8'd4, 1'b0, 1'b0, 2'd0, 1'b0), "pause_resumed");
        push(l + 41, mk(2'd1, 8'd1, 1'b0, 1'b0, 2'd0, 1'b0), "pause_before_exp");
        push(l + 42, mk(2'd1, 8'd0, 1'b1, 1'b0, 2'd0, 1'b0), "pause_delayed_timeout");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        // Normal rinse, then pause exactly on the tick that would expire it.
        drive_act(1'b1, 1'b0, 1'b1, 1'b0);
        push(l + 43, mk(2'd2, 8'd3, 1'b0, 1'b0, 2'd1, 1'b0), "normal_rinse_load");
        push(l + 54, mk(2'd2, 8'd1, 1'b0, 1'b0, 2'd1, 1'b0), "rinse_before_exp");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        pause = 1'b1;
        push(l + 55, mk(2'd2, 8'd1, 1'b0, 1'b0, 2'd1, 1'b0), "pause_blocks_expiry");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        pause = 1'b0;
        push(l + 56, mk(2'd2, 8'd3, 1'b0, 1'b0, 2'd2, 1'b0), "rinse2_after_pause");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
    endtask

    task automatic test_reset_midwash();
        exp_t e;
        int l;
        do_reset();
        program_sel = 2'd3;
        drive_act(1'b1, 1'b1, 1'b0, 1'b0);
        l = edge_cnt + 1;
        push(l,      mk(2'd1, 8'd8, 1'b0, 1'b0, 2'd0, 1'b0), "reserved_wash_load");
        push(l + 12, mk(2'd1, 8'd5, 1'b0, 1'b0, 2'd0, 1'b0), "midwash_count5");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        reset = 1'b1;
        push(l + 13, mk(2'd0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0), "midwash_reset");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        reset = 1'b0;
        push(l + 14, mk(2'd1, 8'd8, 1'b0, 1'b0, 2'd0, 1'b0), "rewash_load");
        push(l + 18, mk(2'd1, 8'd7, 1'b0, 1'b0, 2'd0, 1'b0), "rewash_first_tick");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        done = 1'b1;
        push(l + 19, mk(2'd0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0), "rewash_done");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (edge_cnt < e.at) @(negedge clk);
            n_checks++;
            if (obs() !== e.v) begin
                n_errors++;
                $display("FAIL %s edge %0d: got %h expected %h", e.tag, e.at, obs(), e.v);
            end
        end
        done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_wash();
        test_heavy_rinse();
        test_quick_spin(1'b0);
        test_quick_spin(1'b1);
        test_pause();
        test_reset_midwash();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
